// File: rtl/regfile_pkg.sv
// Shared types and constants for the 32 x 32-bit RISC-V integer register file.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam word_t     ZERO_WORD = {XLEN{1'b0}};
  localparam reg_addr_t X0_ADDR   = {REG_ADDR_W{1'b0}};

  // A write in flight is visible to a read port only if it would actually commit at the falling edge.
  function automatic logic bypass_hit(
    input logic      wr_en,
    input logic      flush,
    input reg_addr_t wr_addr,
    input reg_addr_t rs_addr
  );
    return wr_en && !flush && (wr_addr != X0_ADDR) && (wr_addr == rs_addr);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: x0 reads as zero, optional same-cycle write bypass.
// Bypass is compiled in when REGFILE_WRITE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
(
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       stored_data,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  flush,
  output logic [XLEN-1:0]       rs_data
);

  logic [XLEN-1:0] data_s;

`ifndef REGFILE_WRITE_BYPASS_EN
  logic unused_bypass_s;
  assign unused_bypass_s = ^{wr_en, wr_addr, wr_data, flush};
`endif

  // Select the word presented on this port.
  always_comb begin
    data_s = ZERO_WORD;
    if (!rst_n) begin
      data_s = ZERO_WORD;
    end else if (rs_addr == X0_ADDR) begin
      data_s = ZERO_WORD;
    end else begin
`ifdef REGFILE_WRITE_BYPASS_EN
      if (bypass_hit(wr_en, flush, wr_addr, rs_addr)) begin
        data_s = wr_data;
      end else begin
        data_s = stored_data;
      end
`else
      data_s = stored_data;
`endif
    end
  end

  assign rs_data = data_s;

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit RISC-V integer register file: two read ports, one debug port, falling-edge write.
// Define REGFILE_WRITE_BYPASS_EN to forward an in-flight write to matching read ports.
module register_file
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [XLEN-1:0]       write_data_i,
  input  logic                  reg_write_en,
  input  logic                  global_flush_i,
  input  logic [REG_ADDR_W-1:0] rs_dbg_addr_i,
  output logic [XLEN-1:0]       rs1_data_o,
  output logic [XLEN-1:0]       rs2_data_o,
  output logic [XLEN-1:0]       rs_dbg_data_o
);

  word_t regs_r [1:NUM_REGS-1];
  word_t rf_view_s [0:NUM_REGS-1];
  word_t rs1_stored_s;
  word_t rs2_stored_s;
  word_t dbg_stored_s;

  // Falling-edge write so a value written this cycle is readable before the next rising edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_r[i] <= ZERO_WORD;
      end
    end else if (global_flush_i) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_r[i] <= ZERO_WORD;
      end
    end else if (reg_write_en && (rd_addr_i != X0_ADDR)) begin
      regs_r[rd_addr_i] <= write_data_i;
    end
  end

  // Full 0..31 view with x0 tied to zero so read addressing stays in range.
  always_comb begin
    rf_view_s[0] = ZERO_WORD;
    for (int i = 1; i < NUM_REGS; i++) begin
      rf_view_s[i] = regs_r[i];
    end
  end

  assign rs1_stored_s = rf_view_s[rs1_addr_i];
  assign rs2_stored_s = rf_view_s[rs2_addr_i];
  assign dbg_stored_s = rf_view_s[rs_dbg_addr_i];

  regfile_read_port u_rs1_port (
    .rst_n       (rst_n),
    .rs_addr     (rs1_addr_i),
    .stored_data (rs1_stored_s),
    .wr_en       (reg_write_en),
    .wr_addr     (rd_addr_i),
    .wr_data     (write_data_i),
    .flush       (global_flush_i),
    .rs_data     (rs1_data_o)
  );

  regfile_read_port u_rs2_port (
    .rst_n       (rst_n),
    .rs_addr     (rs2_addr_i),
    .stored_data (rs2_stored_s),
    .wr_en       (reg_write_en),
    .wr_addr     (rd_addr_i),
    .wr_data     (write_data_i),
    .flush       (global_flush_i),
    .rs_data     (rs2_data_o)
  );

  regfile_read_port u_dbg_port (
    .rst_n       (rst_n),
    .rs_addr     (rs_dbg_addr_i),
    .stored_data (dbg_stored_s),
    .wr_en       (reg_write_en),
    .wr_addr     (rd_addr_i),
    .wr_data     (write_data_i),
    .flush       (global_flush_i),
    .rs_data     (rs_dbg_data_o)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed scenarios, randomized traffic and async reset checks.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] write_data_i;
  logic        reg_write_en;
  logic        global_flush_i;
  logic [4:0]  rs_dbg_addr_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [31:0] rs_dbg_data_o;

  register_file dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_addr_i     (rs1_addr_i),
    .rs2_addr_i     (rs2_addr_i),
    .rd_addr_i      (rd_addr_i),
    .write_data_i   (write_data_i),
    .reg_write_en   (reg_write_en),
    .global_flush_i (global_flush_i),
    .rs_dbg_addr_i  (rs_dbg_addr_i),
    .rs1_data_o     (rs1_data_o),
    .rs2_data_o     (rs2_data_o),
    .rs_dbg_data_o  (rs_dbg_data_o)
  );

  typedef struct {
    int          port;
    logic [4:0]  addr;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [32];
  int          errors = 0;
  int          checks = 0;
  event        sample_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Periodic sample point: after the falling-edge write, before the next rising edge.
  always begin
    @(negedge clk);
    #3;
    ->sample_ev;
  end

  // Monitor: pop every pending expectation and compare against the live port.
  always begin
    exp_t        e;
    logic [31:0] act;
    @(sample_ev);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.port)
        0:       act = rs1_data_o;
        1:       act = rs2_data_o;
        default: act = rs_dbg_data_o;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s port%0d addr=%0d actual=%h required=%h", e.tag, e.port, e.addr, act, e.exp);
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  task automatic push_reads(input string tag);
    exp_q.push_back('{0, rs1_addr_i, model_read(rs1_addr_i), tag});
    exp_q.push_back('{1, rs2_addr_i, model_read(rs2_addr_i), tag});
    exp_q.push_back('{2, rs_dbg_addr_i, model_read(rs_dbg_addr_i), tag});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // One clock of stimulus; expectations reflect state after this cycle's falling-edge write.
  task automatic cycle(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic fl, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] ad, input string tag);
    @(posedge clk);
    #1;
    reg_write_en   = we;
    rd_addr_i      = rd;
    write_data_i   = wd;
    global_flush_i = fl;
    rs1_addr_i     = a1;
    rs2_addr_i     = a2;
    rs_dbg_addr_i  = ad;
    if (fl) model_clear();
    else if (we && rd != 5'd0) model[rd] = wd;
    push_reads(tag);
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    rs1_addr_i = 5'd0; rs2_addr_i = 5'd0; rd_addr_i = 5'd0; rs_dbg_addr_i = 5'd0;
    write_data_i = 32'h0; reg_write_en = 1'b0; global_flush_i = 1'b0;

    #2;
    rs1_addr_i = 5'd1; rs2_addr_i = 5'd2; rs_dbg_addr_i = 5'd31;
    push_reads("in_reset");
    ->sample_ev;
    #13;
    rst_n = 1'b1;

    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, "after_reset");
    cycle(1'b1, 5'd1, 32'hDEADBEEF, 1'b0, 5'd1, 5'd0, 5'd1, "write_x1_same_cycle");
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd1, 5'd1, "read_x1");
    cycle(1'b1, 5'd2, 32'hCAFEBABE, 1'b0, 5'd1, 5'd3, 5'd0, "write_x2");
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd2, "dual_read");
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0, "x0_write");
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd1, "dbg_before_flush");
    cycle(1'b1, 5'd3, 32'h12345678, 1'b1, 5'd1, 5'd2, 5'd3, "flush_with_write");
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, "after_flush");

    for (int n = 0; n < 300; n++) begin
      logic [4:0]  rd;
      logic [4:0]  a1;
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 3) != 0), rd, $urandom,
            ($urandom_range(0, 31) == 0), a1, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), "random");
    end

    cycle(1'b1, 5'd1, 32'hA5A5_0001, 1'b0, 5'd1, 5'd7, 5'd1, "pre_async_reset");
    @(posedge clk);
    #2;
    reg_write_en = 1'b1; rd_addr_i = 5'd1; write_data_i = 32'h0BAD_F00D;
    rst_n = 1'b0;
    model_clear();
    #1;
    rs2_addr_i = 5'd1; rs_dbg_addr_i = 5'd7;
    push_reads("async_reset");
    ->sample_ev;
    #1;
    reg_write_en = 1'b0;
    #3;
    rst_n = 1'b1;
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd7, "post_async_reset");
    cycle(1'b1, 5'd9, 32'h5555_AAAA, 1'b0, 5'd9, 5'd1, 5'd9, "write_after_reset");

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
